// File: rtl/key_event_arbiter.sv
// key_event_arbiter: synchronizes N key levels, turns their press/release
// edges into per-key 2-deep event queues, and drains those queues round-robin
// onto one registered valid/ready event stream.
//
// Handshake: an event is transferred on a rising clk edge where evt_valid and
// evt_ready are both high. While evt_valid is high and evt_ready is low, the
// event (evt_key, evt_press) is held stable. A new event may be presented in
// the same cycle the previous one is accepted.
module key_event_arbiter #(
    parameter int N_KEYS = 4,
    localparam int IDX_W = $clog2(N_KEYS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys,
    input  logic              evt_ready,
    input  logic              overrun_clr,
    output logic              evt_valid,
    output logic [IDX_W-1:0]  evt_key,
    output logic              evt_press,
    output logic [N_KEYS-1:0] overrun
);

    // Synchronizer and edge-detect state.
    logic [N_KEYS-1:0] sync1_q, sync2_q, prev_q;

    // Per-key queue: occupancy (0..2) and the type of the oldest entry.
    // The second entry is always the opposite type of the head.
    logic [N_KEYS-1:0][1:0] cnt_q, cnt_d;
    logic [N_KEYS-1:0]      head_q, head_d;

    logic [N_KEYS-1:0] overrun_q, overrun_d, overrun_set;

    // Output stage and round-robin pointer (last granted key).
    logic              valid_q, valid_d;
    logic [IDX_W-1:0]  key_q, key_d;
    logic              press_q, press_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;

    logic [N_KEYS-1:0] rise, fall, push, pending, pop;
    logic              load_en;
    logic              found;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W:0]    cand_sum;
    logic [IDX_W-1:0]  cand;

    assign rise    = sync2_q & ~prev_q;
    assign fall    = ~sync2_q & prev_q;
    assign push    = rise | fall;
    assign load_en = ~valid_q | evt_ready;

    // Pending flags per key.
    always_comb begin
        pending = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            pending[i] = (cnt_q[i] != 2'd0);
        end
    end

    // Round-robin search starting just after the last granted key.
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 1; k <= N_KEYS; k++) begin
            cand_sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (cand_sum >= (IDX_W + 1)'(N_KEYS)) begin
                cand_sum = cand_sum - (IDX_W + 1)'(N_KEYS);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!found && pending[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // Pop strobe for the granted key when the output stage loads.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            pop[i] = load_en && found && (grant == IDX_W'(i));
        end
    end

    // Queue update: push on edge, pop on grant; a push into a full queue
    // without a simultaneous pop is dropped and flagged.
    always_comb begin
        cnt_d       = cnt_q;
        head_d      = head_q;
        overrun_set = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            case ({push[i], pop[i]})
                2'b11: begin
                    head_d[i] = ~head_q[i];
                end
                2'b10: begin
                    if (cnt_q[i] == 2'd2) begin
                        overrun_set[i] = 1'b1;
                    end else begin
                        if (cnt_q[i] == 2'd0) begin
                            head_d[i] = rise[i];
                        end
                        cnt_d[i] = cnt_q[i] + 2'd1;
                    end
                end
                2'b01: begin
                    cnt_d[i]  = cnt_q[i] - 2'd1;
                    head_d[i] = ~head_q[i];
                end
                default: ;
            endcase
        end
    end

    // Sticky overrun flags; a new drop wins over a clear in the same cycle.
    always_comb begin
        overrun_d = (overrun_q & ~{N_KEYS{overrun_clr}}) | overrun_set;
    end

    // Output stage next state: load the granted event or go idle.
    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        press_d = press_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            if (found) begin
                valid_d = 1'b1;
                key_d   = grant;
                press_d = head_q[grant];
                ptr_d   = grant;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            head_q    <= '0;
            overrun_q <= '0;
            valid_q   <= 1'b0;
            key_q     <= '0;
            press_q   <= 1'b0;
            ptr_q     <= IDX_W'(N_KEYS - 1);
        end else begin
            sync1_q   <= keys;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
            key_q     <= key_d;
            press_q   <= press_d;
            ptr_q     <= ptr_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_key   = key_q;
    assign evt_press = press_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed scenarios plus randomized key/ready
// traffic, all checked cycle by cycle against a queue-based reference model.
module tb_key_event_arbiter;

  localparam int N = 4;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  keys = '0;
  logic          evt_ready = 1'b1;
  logic          overrun_clr = 1'b0;
  logic          evt_valid;
  logic [IW-1:0] evt_key;
  logic          evt_press;
  logic [N-1:0]  overrun;

  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  key_event_arbiter #(.N_KEYS(N)) dut (
    .clk(clk), .reset(reset), .keys(keys), .evt_ready(evt_ready),
    .overrun_clr(overrun_clr), .evt_valid(evt_valid), .evt_key(evt_key),
    .evt_press(evt_press), .overrun(overrun)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: key history, per-key event queues, round-robin grant
  bit     m_s1 [N];
  bit     m_s2 [N];
  bit     m_prev [N];
  bit     mq [N][$];
  bit     m_valid;
  int     m_key;
  bit     m_press;
  int     m_ptr;
  bit [N-1:0] m_ovr;

  always @(posedge clk or posedge reset) begin : model
    bit load, found;
    int g, j;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_prev[i] = 0; mq[i].delete();
      end
      m_valid = 0; m_key = 0; m_press = 0; m_ptr = N - 1; m_ovr = '0;
    end else begin
      load = !m_valid || evt_ready;
      found = 0; g = 0;
      if (load) begin
        for (int k = 1; k <= N; k++) begin
          j = (m_ptr + k) % N;
          if (!found && mq[j].size() > 0) begin found = 1; g = j; end
        end
      end
      if (overrun_clr) m_ovr = '0;
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_prev[i]) begin
          if (mq[i].size() < 2 || (found && g == i)) begin
            if (mq[i].size() == 0) mq[i].push_back(m_s2[i]);
            else mq[i].push_back(!mq[i][$]);
          end else begin
            m_ovr[i] = 1'b1;
          end
        end
      end
      if (load) begin
        if (found) begin
          m_valid = 1; m_key = g; m_press = mq[g].pop_front(); m_ptr = g;
        end else begin
          m_valid = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        m_prev[i] = m_s2[i]; m_s2[i] = m_s1[i]; m_s1[i] = keys[i];
      end
    end
  end

  // scoreboard monitor: every cycle the outputs must match the model
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_valid", 32'(evt_valid), 32'(m_valid));
      if (m_valid) begin
        check("mon_key", 32'(evt_key), 32'(m_key));
        check("mon_press", 32'(evt_press), 32'(m_press));
      end
      check("mon_overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("rst_valid", 32'(evt_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_evt(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!evt_valid && n < 30);
    if (!evt_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic expect_evt(input string tag, input int k, input bit p);
    check({tag, "_valid"}, 32'(evt_valid), 1);
    check({tag, "_key"}, 32'(evt_key), 32'(k));
    check({tag, "_press"}, 32'(evt_press), 32'(p));
  endtask

  task automatic count_valid(input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (evt_valid) c++;
    end
  endtask

  int n, c;

  initial begin
    // initial reset
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    mon_en = 1'b1;
    check("reset_valid", 32'(evt_valid), 0);
    check("reset_key", 32'(evt_key), 0);
    check("reset_overrun", 32'(overrun), 0);

    // single key press/release with latency
    @(negedge clk);
    keys[2] = 1'b1;
    wait_evt("t1p", n);
    check("t1_latency_edges", 32'(n - 1), 3);
    expect_evt("t1p", 2, 1'b1);
    @(negedge clk);
    check("t1_one_pulse", 32'(evt_valid), 0);
    keys[2] = 1'b0;
    wait_evt("t1r", n);
    expect_evt("t1r", 2, 1'b0);
    check("t1_overrun", 32'(overrun), 0);

    // three simultaneous presses from reset pointer, then wrap
    do_reset();
    @(negedge clk);
    keys = 4'b1011;
    wait_evt("t2a", n);
    expect_evt("t2a0", 0, 1'b1);
    @(negedge clk); expect_evt("t2a1", 1, 1'b1);
    @(negedge clk); expect_evt("t2a3", 3, 1'b1);
    @(negedge clk); check("t2a_idle", 32'(evt_valid), 0);
    keys = 4'b0000;
    wait_evt("t2b", n);
    expect_evt("t2b0", 0, 1'b0);
    @(negedge clk); expect_evt("t2b1", 1, 1'b0);
    @(negedge clk); expect_evt("t2b3", 3, 1'b0);
    keys = 4'b1011;
    wait_evt("t2c", n);
    expect_evt("t2c_wrap0", 0, 1'b1);
    @(negedge clk); expect_evt("t2c1", 1, 1'b1);
    @(negedge clk); expect_evt("t2c3", 3, 1'b1);

    // backpressure: press/release held behind evt_ready=0
    keys = 4'b0000;
    repeat (8) @(negedge clk);
    evt_ready = 1'b0;
    keys[1] = 1'b1;
    repeat (3) @(negedge clk);
    keys[1] = 1'b0;
    wait_evt("t3", n);
    expect_evt("t3_first", 1, 1'b1);
    c = 0;
    repeat (10) begin
      @(negedge clk);
      if (evt_valid && evt_key == 2'd1 && evt_press) c++;
    end
    check("t3_held_cycles", 32'(c), 10);
    evt_ready = 1'b1;
    @(negedge clk); expect_evt("t3_release", 1, 1'b0);
    @(negedge clk); check("t3_idle", 32'(evt_valid), 0);

    // overrun: output stage busy with key 0, key 1 toggles three times
    evt_ready = 1'b0;
    keys[0] = 1'b1;
    wait_evt("t4", n);
    expect_evt("t4_k0", 0, 1'b1);
    keys[1] = 1'b1; repeat (3) @(negedge clk);
    keys[1] = 1'b0; repeat (3) @(negedge clk);
    keys[1] = 1'b1; repeat (4) @(negedge clk);
    check("t4_overrun_set", 32'(overrun), 32'h2);
    evt_ready = 1'b1;
    @(negedge clk); expect_evt("t4_p", 1, 1'b1);
    @(negedge clk); expect_evt("t4_r", 1, 1'b0);
    @(negedge clk); check("t4_no_third", 32'(evt_valid), 0);
    check("t4_overrun_sticky", 32'(overrun), 32'h2);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("t4_overrun_clr", 32'(overrun), 0);

    // reset with events pending and in flight
    keys = 4'b0000;
    repeat (6) @(negedge clk);
    evt_ready = 1'b0;
    keys = 4'b0111;
    repeat (6) @(negedge clk);
    check("t5_busy", 32'(evt_valid), 1);
    keys = 4'b0000;
    do_reset();
    count_valid(10, c);
    check("t5_no_events", 32'(c), 0);
    evt_ready = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    keys[0] = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    wait_evt("t5k0", n);
    check("t5_latency_edges", 32'(n - 1), 3);
    expect_evt("t5k0", 0, 1'b1);
    count_valid(10, c);
    check("t5_single", 32'(c), 0);

    // randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      evt_ready = ($urandom_range(0, 3) != 0);
      overrun_clr = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) keys[i] = ~keys[i];
      end
    end
    overrun_clr = 1'b0;
    evt_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("final_drained", 32'(evt_valid), 0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_arbiter.md
# key_event_arbiter

Collects press/release edges from N synth key inputs and serializes them onto one valid/ready event stream for the note/voice logic. Each key gets a two-flop synchronizer, edge detection and a 2-deep per-key event queue. A round-robin arbiter drains the queues into a registered output stage. It sits between the DE1-SoC KEY/SW inputs and the synth voice controller, and replaces ad-hoc single-key pulse generators.

## Interface
- N_KEYS, 4, number of key inputs (2..16)
- IDX_W, $clog2(N_KEYS), derived key-index width (localparam)

- clk  input  1  system clock
- reset  input  1  asynchronous, active-high; clears all state
- keys  input  N_KEYS  raw key levels, 1 = pressed (already polarity-corrected), asynchronous to clk
- evt_ready  input  1  consumer accepts the current event when high with evt_valid
- overrun_clr  input  1  one-cycle pulse that clears all overrun bits
- evt_valid  output  1  event present on evt_key/evt_press
- evt_key  output  IDX_W  index of the key the event belongs to
- evt_press  output  1  1 = press (rising edge), 0 = release (falling edge)
- overrun  output  N_KEYS  sticky; bit i is set when an edge on key i was dropped

## Operation
- Reset clears all state to these values:
  - sync stage 1, sync stage 2 and previous-level registers: 0.
  - All queues: empty.
  - evt_valid=0, evt_key=0, evt_press=0.
  - overrun=0.
  - Round-robin pointer: key 0 has highest priority.
- A key held at reset release produces a press event, because its level rises from the reset value 0.
- Edge detect per key: rise = s2 & ~prev; fall = ~s2 & prev.
- Per-key queue state: count (0..2) plus head type bit.
  - Edges alternate, so entry 2's type is always ~head.
  - Push on a detected edge. The head type is set only when count goes 0->1.
  - Pop: count decrements and head type inverts.
  - Push and pop on the same key in the same cycle both take effect; count is unchanged. This is legal even at count=2.
  - Push at count=2 with no pop in that cycle: the edge is dropped and overrun[i] is set.
  - overrun set has priority over overrun_clr in the same cycle.
- Output stage loads when evt_valid==0, or when evt_valid && evt_ready (same-cycle back-to-back is allowed).
  - Grant: the first key with count>0, searching from (last granted + 1) mod N_KEYS upward, with wrap.
  - On load: evt_key = grant, evt_press = head type of that key, that key's queue is popped, and the pointer is set to grant.
  - If no key is pending at a load opportunity: evt_valid goes to 0.
- While evt_valid && !evt_ready: evt_valid, evt_key and evt_press are held stable, and no pop occurs.
- Events from a single key are always delivered in edge order. Across keys, order follows round-robin, not arrival time.
- Reset asserted mid-operation: outputs drop immediately (asynchronous clear). Pending and in-flight events are discarded; no partial event survives.

## Timing
- Key level changes and is stable before edge 0:
  - Edge 0: s1 captures the new level.
  - Edge 1: s2 captures it.
  - Edge 2: the edge is pushed into the queue (prev updated).
  - Edge 3: earliest cycle evt_valid=1, if the output stage is free and the key wins arbitration.
- Minimum latency 3 clocks from input change to evt_valid.
- Throughput: one event per clock while evt_ready=1.
- All outputs are registered. There is no combinational path from keys or evt_ready to any output.
- Input pulses shorter than 1 clock may be missed. Debouncing is the responsibility of upstream logic.

## Test plan
- Reset, then raise keys[2] and hold it with evt_ready=1:
  - evt_valid pulses exactly one cycle, with evt_key=2 and evt_press=1, 3 clocks after the change.
  - Releasing the key gives one event with evt_key=2 and evt_press=0. overrun stays 0.
- Raise keys[0], keys[1] and keys[3] in the same cycle with evt_ready=1:
  - Events arrive on consecutive cycles in order key 0, 1, 3, all with press=1.
  - Repeat the same stimulus: order becomes 0, 1, 3 again only if the pointer has wrapped. Check that the first grant follows last grant (3) + 1 wrapping to 0.
- Hold evt_ready=0 and give keys[1] a press then a release (each ≥2 clocks apart):
  - evt_valid=1 with key=1, press=1, held stable for 10 cycles.
  - Raising evt_ready delivers press then release on consecutive cycles.
- With evt_ready=0, toggle keys[1] three times (press, release, press):
  - overrun[1]=1.
  - The delivered events are press then release only.
  - An overrun_clr pulse returns overrun to 0.
- Assert reset while 3 events are pending and evt_valid=1:
  - evt_valid=0 immediately, and no events appear after reset release if all keys are low.
  - If keys[0] is held high, exactly one press event for key 0 appears 3 clocks after release.
